vx_fpu_ncomp_arb: RTL and testbench

Round-robin arbiter and scheduler that shares one non-computational FPU unit (CMP/SGNJ/CLASS/FMV/MIN/MAX, 2-stage, valid/ready, tagged) among NUM_REQS issue requesters.
- Selects one request per cycle and drives the unit's input port.
- Appends the requester index to the tag.
- Caps in-flight operations with a credit counter.
- Routes each response back to the originating requester by the tag index.
- Sits between the FPU dispatch slots and the shared unit instance.

---
 rtl/vx_fpu_ncomp_arb.sv | 208 ++++++++++++++++++++
 tb/tb_vx_fpu_ncomp_arb.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_fpu_ncomp_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_fpu_ncomp_arb
// Purpose  : Round-robin arbiter that shares one non-computational FPU unit
//            (CMP/SGNJ/CLASS/FMV/MIN/MAX) among NUM_REQS issue requesters.
//            Picks one request per cycle, prefixes the requester index onto
//            the tag, limits in-flight operations with a credit counter and
//            routes each response back to its requester by that index.
// Ports    : clk, reset (sync, active-low)
//            req_*_i / req_ready_o   : per-requester issue ports
//            rsp_*_o / rsp_ready_i   : per-requester response ports (payload
//                                      shared, qualified by rsp_valid_o)
//            unit_*_o / unit_*_i     : shared unit input and output ports
//            perf_stalls_o           : cycles with a request but no issue
// Revision : 1.0 - initial release
// ============================================================================
module vx_fpu_ncomp_arb #(
    parameter  int NUM_REQS      = 4,
    parameter  int NUM_LANES     = 1,
    parameter  int TAGW          = 1,
    parameter  int MAX_PENDING   = 2,
    parameter  int INST_FPU_BITS = 4,
    parameter  int INST_FRM_BITS = 3,
    parameter  int FP_FLAGS_BITS = 5,
    localparam int REQ_SELW      = $clog2(NUM_REQS)
) (
    input  logic                                          clk,
    input  logic                                          reset,

    input  logic [NUM_REQS-1:0]                           req_valid_i,
    output logic [NUM_REQS-1:0]                           req_ready_o,
    input  logic [NUM_REQS-1:0][TAGW-1:0]                 req_tag_i,
    input  logic [NUM_REQS-1:0][INST_FPU_BITS-1:0]        req_op_type_i,
    input  logic [NUM_REQS-1:0][INST_FRM_BITS-1:0]        req_frm_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]      req_dataa_i,
    input  logic [NUM_REQS-1:0][NUM_LANES-1:0][31:0]      req_datab_i,

    output logic [NUM_REQS-1:0]                           rsp_valid_o,
    input  logic [NUM_REQS-1:0]                           rsp_ready_i,
    output logic [NUM_LANES-1:0][31:0]                    rsp_result_o,
    output logic                                          rsp_has_fflags_o,
    output logic [NUM_LANES-1:0][FP_FLAGS_BITS-1:0]       rsp_fflags_o,
    output logic [TAGW-1:0]                               rsp_tag_o,

    output logic                                          unit_valid_in_o,
    input  logic                                          unit_ready_in_i,
    output logic [TAGW+REQ_SELW-1:0]                      unit_tag_in_o,
    output logic [INST_FPU_BITS-1:0]                      unit_op_type_o,
    output logic [INST_FRM_BITS-1:0]                      unit_frm_o,
    output logic [NUM_LANES-1:0][31:0]                    unit_dataa_o,
    output logic [NUM_LANES-1:0][31:0]                    unit_datab_o,

    input  logic                                          unit_valid_out_i,
    output logic                                          unit_ready_out_o,
    input  logic [TAGW+REQ_SELW-1:0]                      unit_tag_out_i,
    input  logic [NUM_LANES-1:0][31:0]                    unit_result_i,
    input  logic                                          unit_has_fflags_i,
    input  logic [NUM_LANES-1:0][FP_FLAGS_BITS-1:0]       unit_fflags_i,

    output logic [31:0]                                   perf_stalls_o
);

    localparam int PW = $clog2(MAX_PENDING + 1);

    // (p + i) mod NUM_REQS, valid for p < NUM_REQS and i < NUM_REQS
    function automatic logic [REQ_SELW-1:0] rr_wrap(input logic [REQ_SELW-1:0] p,
                                                     input int i);
        int s;
        s = int'(p) + i;
        if (s >= NUM_REQS) begin
            s = s - NUM_REQS;
        end
        return REQ_SELW'(s);
    endfunction

    logic [REQ_SELW-1:0] rr_ptr_q,      rr_ptr_d;
    logic [PW-1:0]       pending_q,     pending_d;
    logic                lock_valid_q,  lock_valid_d;
    logic [REQ_SELW-1:0] lock_idx_q,    lock_idx_d;
    logic [31:0]         perf_stalls_q, perf_stalls_d;

    logic                w_rr_found;
    logic [REQ_SELW-1:0] w_rr_idx;
    logic                w_any;
    logic [REQ_SELW-1:0] w_winner;
    logic                w_can_issue;
    logic                w_issue;
    logic                w_retire;
    logic [REQ_SELW-1:0] w_rsp_idx;
    logic                w_rsp_rdy;

    // ------------------------------------------------------------------
    // Round-robin scan starting at rr_ptr
    // ------------------------------------------------------------------
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_rr_found && req_valid_i[rr_wrap(rr_ptr_q, i)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = rr_wrap(rr_ptr_q, i);
            end
        end
    end

    // A stalled offer stays pinned to the same requester until accepted,
    // so the unit never sees its input change mid-handshake.
    assign w_winner = lock_valid_q ? lock_idx_q : w_rr_idx;
    assign w_any    = lock_valid_q | w_rr_found;

    // ------------------------------------------------------------------
    // Response routing by the index carried in the upper tag bits
    // ------------------------------------------------------------------
    assign w_rsp_idx = unit_tag_out_i[TAGW+REQ_SELW-1:TAGW];

    always_comb begin
        w_rsp_rdy   = 1'b0;
        rsp_valid_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_rsp_idx == REQ_SELW'(i)) begin
                w_rsp_rdy      = rsp_ready_i[i];
                rsp_valid_o[i] = reset & unit_valid_out_i;
            end
        end
    end

    assign unit_ready_out_o = reset & w_rsp_rdy;
    assign rsp_tag_o        = unit_tag_out_i[TAGW-1:0];
    assign rsp_result_o     = unit_result_i;
    assign rsp_has_fflags_o = unit_has_fflags_i;
    assign rsp_fflags_o     = unit_fflags_i;

    // ------------------------------------------------------------------
    // Credit check and issue side
    // ------------------------------------------------------------------
    // A retirement in this cycle frees a credit that may be reused at once.
    assign w_retire    = unit_valid_out_i & unit_ready_out_o;
    assign w_can_issue = (pending_q < PW'(MAX_PENDING)) | w_retire;

    assign unit_valid_in_o = reset & w_can_issue & w_any;
    assign w_issue         = unit_valid_in_o & unit_ready_in_i;

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_winner == REQ_SELW'(i)) begin
                req_ready_o[i] = reset & w_any & w_can_issue & unit_ready_in_i;
            end
        end
    end

    assign unit_tag_in_o  = {w_winner, req_tag_i[w_winner]};
    assign unit_op_type_o = req_op_type_i[w_winner];
    assign unit_frm_o     = req_frm_i[w_winner];
    assign unit_dataa_o   = req_dataa_i[w_winner];
    assign unit_datab_o   = req_datab_i[w_winner];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        if (w_issue && !w_retire) begin
            pending_d = pending_q + 1'b1;
        end else if (!w_issue && w_retire && (pending_q != '0)) begin
            pending_d = pending_q - 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (w_issue) begin
            rr_ptr_d = (w_winner == REQ_SELW'(NUM_REQS - 1)) ? '0 : w_winner + 1'b1;
        end

        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        if (w_issue) begin
            lock_valid_d = 1'b0;
        end else if (unit_valid_in_o && !unit_ready_in_i) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = w_winner;
        end

        perf_stalls_d = perf_stalls_q;
        if ((|req_valid_i) && !w_issue) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            pending_q     <= '0;
            lock_valid_q  <= 1'b0;
            lock_idx_q    <= '0;
            perf_stalls_q <= '0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            pending_q     <= pending_d;
            lock_valid_q  <= lock_valid_d;
            lock_idx_q    <= lock_idx_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_stalls_o = perf_stalls_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_fpu_ncomp_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_fpu_ncomp_arb
// Purpose  : Directed self-checking bench for vx_fpu_ncomp_arb. Contains a
//            small behavioural model of the shared unit (2-cycle latency,
//            in order, elastic) that computes FEQ/FMAX and passes other ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_fpu_ncomp_arb;

    localparam int NR = 4;
    localparam int TW = 2;
    localparam logic [3:0] OP_FEQ  = 4'd0;
    localparam logic [3:0] OP_FMAX = 4'd1;
    localparam logic [3:0] OP_MOV  = 4'd2;

    logic clk = 1'b0;
    logic reset;

    logic [NR-1:0]              req_valid, req_ready;
    logic [NR-1:0][TW-1:0]      req_tag;
    logic [NR-1:0][3:0]         req_op;
    logic [NR-1:0][2:0]         req_frm;
    logic [NR-1:0][0:0][31:0]   req_a, req_b;
    logic [NR-1:0]              rsp_valid, rsp_ready;
    logic [0:0][31:0]           rsp_result;
    logic                       rsp_has_fflags;
    logic [0:0][4:0]            rsp_fflags;
    logic [TW-1:0]              rsp_tag;
    logic                       unit_valid_in, unit_ready_in;
    logic [TW+1:0]              unit_tag_in;
    logic [3:0]                 unit_op;
    logic [2:0]                 unit_frm;
    logic [0:0][31:0]           unit_a, unit_b;
    logic                       unit_valid_out, unit_ready_out;
    logic [TW+1:0]              unit_tag_out;
    logic [0:0][31:0]           unit_result;
    logic                       unit_has_fflags;
    logic [0:0][4:0]            unit_fflags;
    logic [31:0]                perf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vx_fpu_ncomp_arb #(
        .NUM_REQS(NR), .NUM_LANES(1), .TAGW(TW), .MAX_PENDING(2),
        .INST_FPU_BITS(4), .INST_FRM_BITS(3), .FP_FLAGS_BITS(5)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_tag_i(req_tag),
        .req_op_type_i(req_op), .req_frm_i(req_frm),
        .req_dataa_i(req_a), .req_datab_i(req_b),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
        .rsp_has_fflags_o(rsp_has_fflags), .rsp_fflags_o(rsp_fflags), .rsp_tag_o(rsp_tag),
        .unit_valid_in_o(unit_valid_in), .unit_ready_in_i(unit_ready_in),
        .unit_tag_in_o(unit_tag_in), .unit_op_type_o(unit_op), .unit_frm_o(unit_frm),
        .unit_dataa_o(unit_a), .unit_datab_o(unit_b),
        .unit_valid_out_i(unit_valid_out), .unit_ready_out_o(unit_ready_out),
        .unit_tag_out_i(unit_tag_out), .unit_result_i(unit_result),
        .unit_has_fflags_i(unit_has_fflags), .unit_fflags_i(unit_fflags),
        .perf_stalls_o(perf)
    );

    // ------------------------------------------------------------------
    // Shared unit model: elastic in-order queue, 2-cycle latency
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction
    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction
    function automatic logic [31:0] ord_key(input logic [31:0] x);
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction
    function automatic logic [31:0] fu_res(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        if (op == OP_FEQ) begin
            return (!is_nan(a) && !is_nan(b) && (a == b)) ? 32'd1 : 32'd0;
        end else if (op == OP_FMAX) begin
            if (is_nan(a)) return b;
            if (is_nan(b)) return a;
            return (ord_key(a) >= ord_key(b)) ? a : b;
        end
        return a;
    endfunction

    logic [TW+1:0] q_tag [8];
    logic [31:0]   q_res [8];
    logic [4:0]    q_ff  [8];
    logic          q_hf  [8];
    int            q_t   [8];
    logic [2:0]    wp = 3'd0, rp = 3'd0;
    int            cyc = 0;

    assign unit_valid_out  = (wp != rp) && (cyc >= q_t[rp] + 2);
    assign unit_tag_out    = q_tag[rp];
    assign unit_result[0]  = q_res[rp];
    assign unit_fflags[0]  = q_ff[rp];
    assign unit_has_fflags = q_hf[rp];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            wp <= 3'd0;
            rp <= 3'd0;
        end else begin
            if (unit_valid_in && unit_ready_in) begin
                q_tag[wp] <= unit_tag_in;
                q_res[wp] <= fu_res(unit_op, unit_a[0], unit_b[0]);
                q_ff[wp]  <= {(unit_op <= OP_FMAX) && (is_snan(unit_a[0]) || is_snan(unit_b[0])), 4'd0};
                q_hf[wp]  <= (unit_op <= OP_FMAX);
                q_t[wp]   <= cyc;
                wp        <= wp + 3'd1;
            end
            if (unit_valid_out && unit_ready_out) begin
                rp <= rp + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic init_payload();
        for (int i = 0; i < NR; i++) begin
            req_tag[i]  = TW'(3 - i);
            req_op[i]   = OP_MOV;
            req_frm[i]  = 3'd0;
            req_a[i][0] = 32'h1000 + i;
            req_b[i][0] = 32'h2000 + i;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 4'hF; rsp_ready = 4'hF; unit_ready_in = 1'b1;
        init_payload();
        next(); next();
        @(negedge clk);
        checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
        checks++; if (unit_valid_in !== 1'b0) begin failures++; $display("FAIL reset_unit_valid_in got=%b exp=0", unit_valid_in); end
        checks++; if (rsp_valid !== 4'h0 || unit_ready_out !== 1'b0) begin failures++; $display("FAIL reset_rsp got=%b/%b exp=0000/0", rsp_valid, unit_ready_out); end
        checks++; if (perf !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d exp=0", perf); end
        next();
        reset = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [1:0] g, r;
        for (int k = 0; k < 12; k++) begin
            req_valid = (k < 10) ? 4'hF : 4'h0;
            @(negedge clk);
            if (k < 10) begin
                g = 2'(k % 4);
                checks++; if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, 4'b0001 << g); end
                checks++; if (unit_tag_in !== {g, 2'(3 - g)}) begin failures++; $display("FAIL rr_tag_in k=%0d got=%h exp=%h", k, unit_tag_in, {g, 2'(3 - g)}); end
            end
            if (k >= 2) begin
                r = 2'((k - 2) % 4);
                checks++; if (rsp_valid !== (4'b0001 << r)) begin failures++; $display("FAIL rr_rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, 4'b0001 << r); end
                checks++; if (rsp_tag !== 2'(3 - r) || rsp_result[0] !== 32'h1000 + r) begin failures++; $display("FAIL rr_rsp_data k=%0d got=%h/%h exp=%h/%h", k, rsp_tag, rsp_result[0], 2'(3 - r), 32'h1000 + r); end
            end
            next();
        end
        checks++; if (perf !== 32'd0) begin failures++; $display("FAIL rr_perf got=%0d exp=0", perf); end
    endtask

    task automatic test_stall_lock();
        // pointer sits at 2 after the previous test
        unit_ready_in = 1'b0; req_valid = 4'b0100;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++; if (unit_valid_in !== 1'b1 || unit_tag_in !== {2'd2, 2'd1} || unit_a[0] !== 32'h1002) begin failures++; $display("FAIL lock_offer s=%0d got=%b/%h/%h exp=1/9/00001002", s, unit_valid_in, unit_tag_in, unit_a[0]); end
            checks++; if (req_ready !== 4'h0) begin failures++; $display("FAIL lock_ready s=%0d got=%b exp=0000", s, req_ready); end
            next();
            req_valid = 4'b0110;
        end
        unit_ready_in = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL lock_accept got=%b exp=0100", req_ready); end
        next();
        req_valid = 4'b1011;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL lock_ptr got=%b exp=1000", req_ready); end
        checks++; if (perf !== 32'd3) begin failures++; $display("FAIL lock_perf got=%0d exp=3", perf); end
        next();
        req_valid = 4'h0;
        repeat (3) next();
    endtask

    task automatic test_credit();
        logic [7:0] exp_rdy;
        exp_rdy = 8'b0111_0011;
        req_valid = 4'b0001; rsp_ready = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) rsp_ready = 4'hF;
            if (k == 7) rsp_ready = 4'b1110;
            @(negedge clk);
            checks++; if (req_ready !== (exp_rdy[k] ? 4'b0001 : 4'b0000) || unit_valid_in !== exp_rdy[k]) begin failures++; $display("FAIL credit_issue k=%0d got=%b/%b exp=%b", k, req_ready, unit_valid_in, exp_rdy[k]); end
            if (k >= 2) begin
                checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL credit_rsp k=%0d got=%b exp=0001", k, rsp_valid); end
            end
            next();
        end
        req_valid = 4'h0; rsp_ready = 4'hF;
        @(negedge clk);
        checks++; if (perf !== 32'd6) begin failures++; $display("FAIL credit_perf got=%0d exp=6", perf); end
        repeat (3) next();
    endtask

    task automatic test_routing();
        req_tag[1] = 2'd1; req_op[1] = OP_FEQ;
        req_a[1][0] = 32'h3F800000; req_b[1][0] = 32'h3F800000;
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL route_feq_issue got=%b exp=0010", req_ready); end
        next();
        req_valid = 4'h0;
        next();
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0010 || rsp_tag !== 2'd1) begin failures++; $display("FAIL route_feq_dest got=%b/%h exp=0010/1", rsp_valid, rsp_tag); end
        checks++; if (rsp_result[0] !== 32'd1 || rsp_fflags[0][4] !== 1'b0 || rsp_has_fflags !== 1'b1) begin failures++; $display("FAIL route_feq_data got=%h/%b/%b exp=1/0/1", rsp_result[0], rsp_fflags[0][4], rsp_has_fflags); end
        next();
        req_op[3] = OP_FMAX; req_a[3][0] = 32'h7FC00000; req_b[3][0] = 32'h40000000;
        req_valid = 4'b1000;
        @(negedge clk);
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL route_fmax_issue got=%b exp=1000", req_ready); end
        next();
        req_valid = 4'h0;
        next();
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b1000 || rsp_tag !== 2'd0 || rsp_result[0] !== 32'h40000000) begin failures++; $display("FAIL route_fmax got=%b/%h/%h exp=1000/0/40000000", rsp_valid, rsp_tag, rsp_result[0]); end
        next(); next();
        init_payload();
    endtask

    task automatic test_reset_midflight();
        req_valid = 4'b0011;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_issue0 got=%b exp=0001", req_ready); end
        next();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL mid_issue1 got=%b exp=0010", req_ready); end
        next();
        reset = 1'b0; req_valid = 4'b0110;
        @(negedge clk);
        checks++; if (req_ready !== 4'h0 || rsp_valid !== 4'h0 || unit_valid_in !== 1'b0 || unit_ready_out !== 1'b0) begin failures++; $display("FAIL mid_in_reset got=%b/%b/%b/%b exp=0000/0000/0/0", req_ready, rsp_valid, unit_valid_in, unit_ready_out); end
        next();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010 || rsp_valid !== 4'h0) begin failures++; $display("FAIL mid_after_grant got=%b/%b exp=0010/0000", req_ready, rsp_valid); end
        checks++; if (perf !== 32'd0) begin failures++; $display("FAIL mid_perf got=%0d exp=0", perf); end
        next();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_second got=%b exp=0100", req_ready); end
        next();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010 || rsp_valid !== 4'b0010) begin failures++; $display("FAIL mid_credit got=%b/%b exp=0010/0010", req_ready, rsp_valid); end
        next();
        req_valid = 4'h0;
        repeat (3) next();
    endtask

    task automatic test_single();
        reset = 1'b0;
        next();
        reset = 1'b1; req_valid = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL single_grant k=%0d got=%b exp=1000", k, req_ready); end
            if (k >= 2) begin
                checks++; if (rsp_valid !== 4'b1000 || rsp_tag !== 2'd0) begin failures++; $display("FAIL single_rsp k=%0d got=%b/%h exp=1000/0", k, rsp_valid, rsp_tag); end
            end
            next();
        end
        req_valid = 4'b1001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_wrap got=%b exp=0001", req_ready); end
        checks++; if (perf !== 32'd0) begin failures++; $display("FAIL single_perf got=%0d exp=0", perf); end
        next();
        req_valid = 4'h0;
        repeat (3) next();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_stall_lock();
        test_credit();
        test_routing();
        test_reset_midflight();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
